// File: rtl/sensor_cfg_pkg.sv
// Shared types and constants for the image-sensor configuration controller
// and its register initialisation table.
package sensor_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWDN,
    ST_RST,
    ST_BOOT,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int          TBL_W      = 24;
  localparam logic [15:0] DELAY_MARK = 16'hFFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  val;
  } tbl_entry_t;

  function automatic logic is_delay(input tbl_entry_t e);
    return e.addr == DELAY_MARK;
  endfunction

endpackage

// File: rtl/sensor_cfg_rom.sv
// Sensor register initialisation table, registered read with one cycle of
// latency; entries are {reg_addr, reg_val} or {DELAY_MARK, ms}.
module sensor_cfg_rom
  import sensor_cfg_pkg::*;
(
  input  logic             clk_i,
  input  logic [7:0]       addr_i,
  output logic [TBL_W-1:0] data_o
);

  tbl_entry_t w_entry;

  // Unpopulated indices read as a zero-length delay so an oversized count is harmless.
  always_comb begin
    w_entry = {DELAY_MARK, 8'd0};
    case (addr_i)
      8'd0:    w_entry = {16'h3008, 8'h82};
      8'd1:    w_entry = {DELAY_MARK, 8'd5};
      8'd2:    w_entry = {16'h3008, 8'h42};
      8'd3:    w_entry = {16'h3103, 8'h03};
      8'd4:    w_entry = {16'h3017, 8'hFF};
      8'd5:    w_entry = {16'h3018, 8'hFF};
      8'd6:    w_entry = {16'h3034, 8'h1A};
      8'd7:    w_entry = {16'h3037, 8'h13};
      8'd8:    w_entry = {16'h3108, 8'h01};
      8'd9:    w_entry = {16'h3630, 8'h36};
      default: w_entry = {DELAY_MARK, 8'd0};
    endcase
  end

  always_ff @(posedge clk_i) begin
    data_o <= w_entry;
  end

endmodule

// File: rtl/sensor_cfg_ctrl.sv
// Image-sensor bring-up: power-down / reset / boot timing, then walks the
// register table issuing SCCB writes with bounded retry on NACK.
module sensor_cfg_ctrl
  import sensor_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned PWDN_MS     = 5,
  parameter int unsigned RST_MS      = 5,
  parameter int unsigned BOOT_MS     = 20,
  parameter logic [7:0]  REG_NUM     = 8'd165,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             cmos_pwdn_o,
  output logic             cmos_rstn_o,
  output logic [7:0]       tbl_addr_o,
  input  logic [TBL_W-1:0] tbl_data_i,
  output logic             wr_req_o,
  output logic [15:0]      wr_addr_o,
  output logic [7:0]       wr_data_o,
  input  logic             wr_done_i,
  input  logic             wr_nack_i,
  output logic             cfg_done_o,
  output logic             cfg_err_o
);

  localparam logic [31:0] TICK_LAST = 32'(CLK_FREQ_HZ / 1000 - 1);

  state_t      r_state;
  logic [31:0] r_tick_cnt;
  logic [7:0]  r_ms_cnt;
  logic [7:0]  r_dly_ms;
  logic [7:0]  r_try;
  logic        r_fetch_wait;
  logic        r_pwdn;
  logic        r_rstn;
  logic        r_req;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_tbl_addr;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;

  tbl_entry_t  w_entry;
  logic        w_tick;
  logic        w_wait_end;
  logic        w_entry_end;
  logic        w_last;
  logic [7:0]  w_wait_ms;

  assign w_entry    = tbl_entry_t'(tbl_data_i);
  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_wait_end = w_tick && ((r_ms_cnt + 8'd1) == w_wait_ms);
  assign w_last     = (r_tbl_addr == REG_NUM - 8'd1);

  // w_entry_end marks the cycle the current table entry is finished (write acked or delay over).
  always_comb begin
    w_wait_ms   = r_dly_ms;
    w_entry_end = 1'b0;
    case (r_state)
      ST_PWDN:  w_wait_ms   = 8'(PWDN_MS);
      ST_RST:   w_wait_ms   = 8'(RST_MS);
      ST_BOOT:  w_wait_ms   = 8'(BOOT_MS);
      ST_FETCH: w_entry_end = r_fetch_wait && is_delay(w_entry) && (w_entry.val == 8'd0);
      ST_WAIT:  w_entry_end = wr_done_i && !wr_nack_i;
      ST_DELAY: w_entry_end = w_wait_end;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_pwdn       <= 1'b1;
      r_rstn       <= 1'b0;
      r_req        <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_tbl_addr   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_tick_cnt   <= '0;
      r_ms_cnt     <= '0;
      r_dly_ms     <= '0;
      r_try        <= '0;
      r_fetch_wait <= 1'b0;
    end else if (start_i) begin
      r_state      <= ST_PWDN;
      r_pwdn       <= 1'b1;
      r_rstn       <= 1'b0;
      r_req        <= 1'b0;
      r_tbl_addr   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_tick_cnt   <= '0;
      r_ms_cnt     <= '0;
      r_try        <= '0;
      r_fetch_wait <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
      r_ms_cnt   <= r_ms_cnt + {7'd0, w_tick};
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_PWDN;
          r_pwdn     <= 1'b1;
          r_rstn     <= 1'b0;
          r_tick_cnt <= '0;
          r_ms_cnt   <= '0;
        end
        ST_PWDN: if (w_wait_end) begin
          r_state    <= ST_RST;
          r_pwdn     <= 1'b0;
          r_tick_cnt <= '0;
          r_ms_cnt   <= '0;
        end
        ST_RST: if (w_wait_end) begin
          r_state    <= ST_BOOT;
          r_rstn     <= 1'b1;
          r_tick_cnt <= '0;
          r_ms_cnt   <= '0;
        end
        ST_BOOT: if (w_wait_end) begin
          r_state      <= ST_FETCH;
          r_tbl_addr   <= '0;
          r_fetch_wait <= 1'b0;
        end
        // First FETCH cycle covers the table read latency; the second consumes the entry.
        ST_FETCH: begin
          if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_fetch_wait <= 1'b0;
            if (is_delay(w_entry)) begin
              if (w_entry.val != 8'd0) begin
                r_state    <= ST_DELAY;
                r_dly_ms   <= w_entry.val;
                r_tick_cnt <= '0;
                r_ms_cnt   <= '0;
              end
            end else begin
              r_wr_addr <= w_entry.addr;
              r_wr_data <= w_entry.val;
              r_req     <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_req   <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: if (wr_done_i) begin
          r_req <= 1'b0;
          if (wr_nack_i) begin
            if ((r_try + 8'd1) < 8'(MAX_RETRY)) begin
              r_try   <= r_try + 8'd1;
              r_state <= ST_ISSUE;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      // Entry completion overrides the per-state assignments above.
      if (w_entry_end) begin
        if (w_last) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end else begin
          r_tbl_addr <= r_tbl_addr + 8'd1;
          r_try      <= '0;
          r_state    <= ST_FETCH;
        end
      end
    end
  end

  assign cmos_pwdn_o = r_pwdn;
  assign cmos_rstn_o = r_rstn;
  assign tbl_addr_o  = r_tbl_addr;
  assign wr_req_o    = r_req;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign cfg_done_o  = r_done;
  assign cfg_err_o   = r_err;

endmodule

// File: tb/tb_sensor_cfg_ctrl.sv
// Directed bench: a 1 MHz instance for power/delay timing and a fast-tick
// instance for write order, NACK retry, error and restart behaviour.
module tb_sensor_cfg_ctrl;

  localparam logic [23:0] TB_B0 = 24'h300882;
  localparam logic [23:0] TB_B1 = 24'h310303;
  localparam logic [23:0] TB_B2 = 24'h3017FF;
  localparam logic [23:0] TB_B3 = 24'h3018FF;
  localparam logic [23:0] TB_A0 = 24'h430061;
  localparam logic [23:0] TB_A1 = 24'hFFFF02;
  localparam logic [23:0] TB_A2 = 24'h501F01;
  localparam logic [23:0] TB_A3 = 24'h382040;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] tbl_b(input logic [7:0] a);
    case (a)
      8'd0: return TB_B0;
      8'd1: return TB_B1;
      8'd2: return TB_B2;
      8'd3: return TB_B3;
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [23:0] tbl_a(input logic [7:0] a);
    case (a)
      8'd0: return TB_A0;
      8'd1: return TB_A1;
      8'd2: return TB_A2;
      8'd3: return TB_A3;
      default: return 24'h0;
    endcase
  endfunction

  // ---------------- fast-tick instance (10 clocks per ms) ----------------
  logic        s_start, s_stray, s_mdone, s_mnack;
  logic        s_pwdn, s_rstn, s_req, s_done, s_err;
  logic [7:0]  s_taddr, s_wdata;
  logic [15:0] s_waddr;
  logic [23:0] s_tdata;
  int          mode;
  int          s_acnt = 0;
  int          s_e2_tries = 0;
  logic        s_req_q = 1'b0;
  logic [23:0] s_log[$];

  sensor_cfg_ctrl #(.CLK_FREQ_HZ(10_000), .REG_NUM(8'd4)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start),
    .cmos_pwdn_o(s_pwdn), .cmos_rstn_o(s_rstn),
    .tbl_addr_o(s_taddr), .tbl_data_i(s_tdata),
    .wr_req_o(s_req), .wr_addr_o(s_waddr), .wr_data_o(s_wdata),
    .wr_done_i(s_mdone | s_stray), .wr_nack_i(s_mnack),
    .cfg_done_o(s_done), .cfg_err_o(s_err)
  );

  always @(posedge clk) s_tdata <= tbl_b(s_taddr);

  // Slave model: done 10 cycles after request; entry 2 (0x3017) NACK per mode.
  always @(posedge clk) begin
    s_mdone <= 1'b0;
    s_mnack <= 1'b0;
    if (s_start) s_e2_tries <= 0;
    if (!s_req) begin
      s_acnt <= 0;
    end else if (s_acnt == 9) begin
      s_acnt  <= 0;
      s_mdone <= 1'b1;
      if (s_waddr == 16'h3017) begin
        s_mnack    <= (mode == 2) || (mode == 1 && s_e2_tries < 2);
        s_e2_tries <= s_e2_tries + 1;
      end
    end else begin
      s_acnt <= s_acnt + 1;
    end
  end

  always @(posedge clk) begin
    s_req_q <= s_req;
    if (s_req && !s_req_q) s_log.push_back({s_waddr, s_wdata});
  end

  function automatic int count_addr(input int base, input logic [15:0] a);
    int n = 0;
    for (int i = base; i < s_log.size(); i++)
      if (s_log[i][23:8] == a) n++;
    return n;
  endfunction

  // ---------------- 1 MHz instance ----------------
  logic        b_start = 1'b0;
  logic        b_nack = 1'b0;
  logic        b_mdone;
  logic        b_pwdn, b_rstn, b_req, b_done, b_err;
  logic [7:0]  b_taddr, b_wdata;
  logic [15:0] b_waddr;
  logic [23:0] b_tdata;
  int          b_acnt = 0;
  logic        b_req_q = 1'b0;
  logic        b_req_n = 1'b0;
  logic [23:0] b_log[$];
  int          pc = -1;
  int          b_pwdn_cnt = 0, b_rstn_lo_cnt = 0;
  int          b_rises = 0, b_falls = 0;
  int          b_rise1 = 0, b_rise2 = 0, b_fall1 = 0;

  sensor_cfg_ctrl #(.CLK_FREQ_HZ(1_000_000), .REG_NUM(8'd4)) u_big (
    .clk_i(clk), .rst_i(rst), .start_i(b_start),
    .cmos_pwdn_o(b_pwdn), .cmos_rstn_o(b_rstn),
    .tbl_addr_o(b_taddr), .tbl_data_i(b_tdata),
    .wr_req_o(b_req), .wr_addr_o(b_waddr), .wr_data_o(b_wdata),
    .wr_done_i(b_mdone), .wr_nack_i(b_nack),
    .cfg_done_o(b_done), .cfg_err_o(b_err)
  );

  always @(posedge clk) b_tdata <= tbl_a(b_taddr);

  always @(posedge clk) begin
    b_mdone <= 1'b0;
    if (!b_req) b_acnt <= 0;
    else if (b_acnt == 9) begin
      b_acnt  <= 0;
      b_mdone <= 1'b1;
    end else b_acnt <= b_acnt + 1;
    b_req_q <= b_req;
    if (b_req && !b_req_q) b_log.push_back({b_waddr, b_wdata});
  end

  // pc = index of the posedge since reset release; edge 0 leaves IDLE.
  always @(posedge clk) pc <= rst ? -1 : pc + 1;

  always @(negedge clk) begin
    b_req_n <= b_req;
    if (pc >= 0) begin
      if (b_pwdn) b_pwdn_cnt <= b_pwdn_cnt + 1;
      if (!b_rstn) b_rstn_lo_cnt <= b_rstn_lo_cnt + 1;
      if (b_req && !b_req_n) begin
        b_rises <= b_rises + 1;
        if (b_rises == 0) b_rise1 <= pc;
        if (b_rises == 1) b_rise2 <= pc;
      end
      if (!b_req && b_req_n) begin
        b_falls <= b_falls + 1;
        if (b_falls == 0) b_fall1 <= pc;
      end
    end
  end

  // ---------------- standalone table ROM ----------------
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;

  sensor_cfg_rom u_rom (.clk_i(clk), .addr_i(rom_addr), .data_o(rom_data));

  task automatic wait_small_end(input int max, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (s_done || s_err) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit hit;
    int base;
    rst = 1'b1; s_start = 1'b0; s_stray = 1'b0; mode = 0; rom_addr = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pwdn",  s_pwdn,  1);
    check_val("rst_rstn",  s_rstn,  0);
    check_val("rst_req",   s_req,   0);
    check_val("rst_waddr", s_waddr, 0);
    check_val("rst_wdata", s_wdata, 0);
    check_val("rst_taddr", s_taddr, 0);
    check_val("rst_done",  s_done,  0);
    check_val("rst_err",   s_err,   0);
    check_val("rst_b_pwdn", b_pwdn, 1);
    @(negedge clk);
    check_val("rom_e0", rom_data, 24'h300882);
    rom_addr = 8'd1;
    @(negedge clk);
    check_val("rom_e1", rom_data, 24'hFFFF05);
    rst = 1'b0;

    // Auto-run after reset, all entries acked.
    wait_small_end(2000, hit);
    check_val("s1_end_seen", hit, 1);
    check_val("s1_done", s_done, 1);
    check_val("s1_err", s_err, 0);
    check_val("s1_nwr", s_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("s1_wr%0d", i), (i < s_log.size()) ? s_log[i] : 24'h0, tbl_b(8'(i)));
    repeat (30) @(negedge clk);
    check_val("s1_hold_done", s_done, 1);
    check_val("s1_taddr", s_taddr, 3);
    check_val("s1_hold_req", s_req, 0);

    // Entry 2 NACKs twice then ACKs.
    mode = 1;
    base = s_log.size();
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    check_val("s2_done_clr", s_done, 0);
    check_val("s2_pwdn", s_pwdn, 1);
    wait_small_end(2000, hit);
    check_val("s2_end_seen", hit, 1);
    check_val("s2_done", s_done, 1);
    check_val("s2_nwr", s_log.size() - base, 6);
    check_val("s2_e2_reqs", count_addr(base, 16'h3017), 3);
    check_val("s2_last_wr", s_log[s_log.size() - 1], TB_B3);

    // Entry 2 always NACKs: three attempts then error.
    mode = 2;
    base = s_log.size();
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    check_val("s3_done_clr", s_done, 0);
    wait_small_end(2000, hit);
    check_val("s3_end_seen", hit, 1);
    check_val("s3_err", s_err, 1);
    check_val("s3_done", s_done, 0);
    check_val("s3_e2_reqs", count_addr(base, 16'h3017), 3);
    repeat (200) @(negedge clk);
    check_val("s3_nwr_hold", s_log.size() - base, 5);
    check_val("s3_req_hold", s_req, 0);
    check_val("s3_err_hold", s_err, 1);

    // Restart while waiting on entry 1, then a stray completion pulse.
    mode = 0;
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    check_val("s4_err_clr", s_err, 0);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_req && s_waddr == 16'h3103) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("s4_e1_req_seen", hit, 1);
    repeat (3) @(negedge clk);
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    check_val("s4_req_drop", s_req, 0);
    check_val("s4_pwdn", s_pwdn, 1);
    base = s_log.size();
    repeat (2) @(negedge clk);
    s_stray = 1'b1; @(negedge clk); s_stray = 1'b0;
    @(negedge clk);
    check_val("s4_stray_taddr", s_taddr, 0);
    check_val("s4_stray_pwdn", s_pwdn, 1);
    check_val("s4_stray_done", s_done, 0);
    wait_small_end(2000, hit);
    check_val("s4_end_seen", hit, 1);
    check_val("s4_done", s_done, 1);
    check_val("s4_nwr", s_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("s4_wr%0d", i), (base + i < s_log.size()) ? s_log[base + i] : 24'h0, tbl_b(8'(i)));

    // 1 MHz instance: 1000-cycle tick, table A with a 2 ms delay at index 1.
    hit = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (b_done || b_err) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("b_end_seen", hit, 1);
    check_val("b_done", b_done, 1);
    check_val("b_err", b_err, 0);
    check_val("b_pwdn_cycles", b_pwdn_cnt, 5000);
    check_val("b_rstn_lo_cycles", b_rstn_lo_cnt, 10000);
    check_val("b_first_req", b_rise1, 30002);
    check_val("b_first_req_end", b_fall1, 30013);
    // Low time: 2 cycles marker fetch + 2000 delay + 2 cycles fetch of entry 2.
    check_val("b_delay_gap", b_rise2 - b_fall1, 2004);
    check_val("b_nwr", b_log.size(), 3);
    check_val("b_wr0", (b_log.size() > 0) ? b_log[0] : 24'h0, TB_A0);
    check_val("b_wr1", (b_log.size() > 1) ? b_log[1] : 24'h0, TB_A2);
    check_val("b_wr2", (b_log.size() > 2) ? b_log[2] : 24'h0, TB_A3);
    check_val("b_taddr", b_taddr, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
